// File: rtl/rmt_pkg.sv
// Shared constants for the RMT custom UDP framing, used by both the ingress
// classifier and the egress reply generator.
package rmt_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4_LE = 16'h0008;
    localparam logic [15:0] RMT_DELIM         = 16'hF0E1;

    localparam int unsigned MAC_BYTES      = 6;
    localparam int unsigned IP_ADDR_BYTES  = 4;
    localparam int unsigned UDP_PORT_BYTES = 2;

    localparam int unsigned OFF_MAC_DST   = 0;
    localparam int unsigned OFF_MAC_SRC   = 6;
    localparam int unsigned OFF_ETHERTYPE = 12;
    localparam int unsigned OFF_IP_SRC    = 26;
    localparam int unsigned OFF_IP_DST    = 30;
    localparam int unsigned OFF_UDP_SPORT = 34;
    localparam int unsigned OFF_UDP_DPORT = 36;
    localparam int unsigned OFF_UDP_CSUM  = 40;
    localparam int unsigned OFF_DELIM     = 42;
    localparam int unsigned OFF_FUNC      = 44;
    localparam int unsigned HDR_BYTES     = 46;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_TRANSFER = 2'd1;
    localparam logic [1:0] ST_DROP     = 2'd2;

endpackage

// File: rtl/rmt_tx_if.sv
// AXI-Stream bundle carrying N parallel lanes; N=1 for the merged egress side.
interface rmt_tx_if #(
    parameter int unsigned N          = 1,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 8
);

    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N*USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/rmt_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rmt_rr_arbiter #(
    parameter int unsigned S_COUNT = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [S_COUNT-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_valid
);

    // Upper segment [ptr, S_COUNT) wins over the wrapped segment [0, ptr).
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            if (!o_valid && i_req[i] && (i >= 32'(i_ptr))) begin
                o_grant = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            if (!o_valid && i_req[i] && (i < 32'(i_ptr))) begin
                o_grant = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rmt_tx.sv
// RMT egress: round-robin packet merge of function-engine replies with a
// first-beat header rewrite (address/port swap, fixed framing fields).
module rmt_tx
    import rmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned S_COUNT    = 2,
    parameter int unsigned FUNC_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    rmt_tx_if.slave     s_axis,
    rmt_tx_if.master    m_axis,
    output logic [31:0] stat_pkt_count,
    output logic [31:0] stat_drop_count
);

    localparam int unsigned IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_arb_grant;
    logic                  w_arb_valid;
    logic [IDX_W-1:0]      w_sel;
    logic                  w_sel_valid;
    logic [IDX_W-1:0]      w_rr_nxt;

    logic [DATA_WIDTH-1:0] w_src_tdata;
    logic [KEEP_WIDTH-1:0] w_src_tkeep;
    logic                  w_src_tvalid;
    logic                  w_src_tlast;
    logic [USER_WIDTH-1:0] w_src_tuser;
    logic [DATA_WIDTH-1:0] w_reply_tdata;
    logic [DATA_WIDTH-1:0] w_out_tdata;

    logic                  w_load_en;
    logic                  w_src_ready;
    logic                  w_hs;
    logic                  w_short;
    logic [S_COUNT-1:0]    w_tready;

    logic                  w_out_load;
    logic                  w_out_modify;
    logic                  w_grant_load;
    logic                  w_pkt_done;
    logic                  w_drop_inc;

    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [USER_WIDTH-1:0] r_m_tuser;
    logic [31:0]           r_pkt_cnt;
    logic [31:0]           r_drop_cnt;

    rmt_rr_arbiter #(
        .S_COUNT (S_COUNT),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (s_axis.tvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_valid (w_arb_valid)
    );

    // In IDLE the live arbiter pick is the grant; afterwards it is locked until tlast.
    assign w_sel       = (r_state == ST_IDLE) ? w_arb_grant : r_grant;
    assign w_sel_valid = (r_state == ST_IDLE) ? w_arb_valid : 1'b1;
    assign w_load_en   = !r_m_tvalid || m_axis.tready[0];
    assign w_src_ready = (r_state == ST_DROP) ? 1'b1 : w_load_en;
    assign w_hs        = !rst && w_sel_valid && w_src_tvalid && w_src_ready;
    assign w_short     = ~&w_src_tkeep[HDR_BYTES-1:0];
    assign w_rr_nxt    = (w_sel == IDX_W'(S_COUNT - 1)) ? '0 : w_sel + IDX_W'(1);

    always_comb begin
        w_src_tdata  = '0;
        w_src_tkeep  = '0;
        w_src_tvalid = 1'b0;
        w_src_tlast  = 1'b0;
        w_src_tuser  = '0;
        w_tready     = '0;
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_src_tdata  = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_src_tkeep  = s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_src_tvalid = s_axis.tvalid[i];
                w_src_tlast  = s_axis.tlast[i];
                w_src_tuser  = s_axis.tuser[i*USER_WIDTH +: USER_WIDTH];
                w_tready[i]  = !rst && w_sel_valid && w_src_ready;
            end
        end
    end

    assign s_axis.tready = w_tready;

    // Reply header: swap address pairs, force framing fields; IPv4 checksum is
    // left alone because swapping src/dst keeps the one's-complement sum.
    always_comb begin
        w_reply_tdata = w_src_tdata;
        for (int unsigned b = 0; b < MAC_BYTES; b++) begin
            w_reply_tdata[(OFF_MAC_DST+b)*8 +: 8] = w_src_tdata[(OFF_MAC_SRC+b)*8 +: 8];
            w_reply_tdata[(OFF_MAC_SRC+b)*8 +: 8] = w_src_tdata[(OFF_MAC_DST+b)*8 +: 8];
        end
        for (int unsigned b = 0; b < IP_ADDR_BYTES; b++) begin
            w_reply_tdata[(OFF_IP_SRC+b)*8 +: 8] = w_src_tdata[(OFF_IP_DST+b)*8 +: 8];
            w_reply_tdata[(OFF_IP_DST+b)*8 +: 8] = w_src_tdata[(OFF_IP_SRC+b)*8 +: 8];
        end
        for (int unsigned b = 0; b < UDP_PORT_BYTES; b++) begin
            w_reply_tdata[(OFF_UDP_SPORT+b)*8 +: 8] = w_src_tdata[(OFF_UDP_DPORT+b)*8 +: 8];
            w_reply_tdata[(OFF_UDP_DPORT+b)*8 +: 8] = w_src_tdata[(OFF_UDP_SPORT+b)*8 +: 8];
        end
        w_reply_tdata[OFF_ETHERTYPE*8 +: 16]      = ETHERTYPE_IPV4_LE;
        w_reply_tdata[OFF_UDP_CSUM*8 +: 16]       = 16'h0000;
        w_reply_tdata[OFF_DELIM*8 +: 16]          = RMT_DELIM;
        w_reply_tdata[OFF_FUNC*8 +: FUNC_WIDTH]   = FUNC_WIDTH'(w_sel);
    end

    assign w_out_tdata = w_out_modify ? w_reply_tdata : w_src_tdata;

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_load   = 1'b0;
        w_out_modify = 1'b0;
        w_grant_load = 1'b0;
        w_pkt_done   = 1'b0;
        w_drop_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_grant_load = 1'b1;
                    if (w_short) begin
                        if (w_src_tlast) begin
                            w_drop_inc = 1'b1;
                            w_pkt_done = 1'b1;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end else begin
                        w_out_load   = 1'b1;
                        w_out_modify = 1'b1;
                        if (w_src_tlast) begin
                            w_pkt_done = 1'b1;
                        end else begin
                            w_state_nxt = ST_TRANSFER;
                        end
                    end
                end
            end
            ST_TRANSFER: begin
                if (w_hs) begin
                    w_out_load = 1'b1;
                    if (w_src_tlast) begin
                        w_pkt_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (w_hs && w_src_tlast) begin
                    w_drop_inc  = 1'b1;
                    w_pkt_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant/pointer bookkeeping, output register and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_grant_load) begin
                r_grant <= w_sel;
            end
            if (w_pkt_done) begin
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_drop_inc) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (w_out_load) begin
                r_m_tdata  <= w_out_tdata;
                r_m_tkeep  <= w_src_tkeep;
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_src_tlast;
                r_m_tuser  <= w_src_tuser;
                if (w_src_tlast) begin
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
            end else if (m_axis.tready[0]) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis.tdata     = r_m_tdata;
    assign m_axis.tkeep     = r_m_tkeep;
    assign m_axis.tvalid[0] = r_m_tvalid;
    assign m_axis.tlast[0]  = r_m_tlast;
    assign m_axis.tuser     = r_m_tuser;
    assign stat_pkt_count   = r_pkt_cnt;
    assign stat_drop_count  = r_drop_cnt;

endmodule

// File: doc/rmt_tx.md
Name: rmt_tx

Overview:
- Egress counterpart to the ingress RMT classifier; the two share the same custom UDP framing.
- Accepts response packets from S_COUNT function engines as AXI-Stream, arbitrates round-robin per packet, and emits one merged stream toward the MAC TX path.
- On the first beat of every packet it turns the header into a reply:
  - swaps MAC, IPv4 address and UDP port fields;
  - forces ether_type, the 0xF0E1 delimiter and the func_type field;
  - zeroes the UDP checksum.
- Drops runt first beats that cannot hold the 46-byte header.

Parameters:
- DATA_WIDTH, 512, tdata width in bits; must be >= 368 (46 bytes).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 8, tuser width, passed through unchanged.
- S_COUNT, 2, number of function-engine input ports.
- FUNC_WIDTH, 16, width of the func_type field; source index is zero-extended into it.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  per-source data
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  per-source byte enables
- s_axis_tvalid  in  S_COUNT  per-source valid
- s_axis_tready  out  S_COUNT  per-source ready
- s_axis_tlast  in  S_COUNT  per-source last
- s_axis_tuser  in  S_COUNT*USER_WIDTH  per-source user
- m_axis_tdata  out  DATA_WIDTH  merged data
- m_axis_tkeep  out  KEEP_WIDTH  merged keep
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  merged last
- m_axis_tuser  out  USER_WIDTH  merged user
- stat_pkt_count  out  32  packets forwarded (counted at tlast)
- stat_drop_count  out  32  packets dropped

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - outputs: m_axis_tvalid=0, all s_axis_tready=0, both stat counters=0, other m_axis_* = 0;
  - state: state=IDLE, rr pointer=0.
- Output register:
  - single register stage; 1-cycle latency from input handshake to m_axis_tvalid;
  - load enable = !m_axis_tvalid || m_axis_tready, which gives full throughput;
  - m_axis_* must hold stable while tvalid && !tready.
- s_axis_tready[i] = (grant==i) && load enable, except in DROP where it is (grant==i) only. Non-granted ports always see 0.
- State machine:
  - IDLE:
    - combinational round-robin pick: first valid port at or after rr pointer, wrapping;
    - grant index registered on the first-beat handshake;
    - first beat is "short" if any of tkeep[45:0] is 0;
    - short + tlast: discard beat, stat_drop_count++, stay IDLE;
    - short + !tlast: discard beat, go DROP;
    - otherwise: write the modified beat to the output register; go TRANSFER if !tlast, else stay IDLE.
  - TRANSFER: pass beats of the granted port unmodified; on handshake with tlast go IDLE.
  - DROP: consume the granted port's beats without output; on tlast increment stat_drop_count and go IDLE.
- Round-robin pointer:
  - updated to grant+1 (mod S_COUNT) when a packet finishes, whether forwarded or dropped;
  - grant is locked until tlast; no interleaving.
- First-beat header rewrite (lane b = tdata[b*8+:8]; 16-bit fields use tdata[off*8+:16]):
  - bytes 0-5 <-> bytes 6-11 (MAC dst/src swap);
  - tdata[12*8+:16] = 16'h0008;
  - bytes 26-29 <-> bytes 30-33 (IPv4 src/dst swap); IPv4 checksum untouched, since the swap preserves the one's-complement sum;
  - bytes 34-35 <-> bytes 36-37 (UDP port swap);
  - tdata[40*8+:16] = 16'h0000 (UDP checksum disabled);
  - tdata[42*8+:16] = 16'hF0E1;
  - tdata[44*8+:16] = grant index zero-extended to FUNC_WIDTH;
  - all other bytes, tkeep, tuser and tlast pass unchanged.
- Counters: stat_pkt_count increments when a beat with tlast is loaded into the output register. Both counters wrap at 2^32.
- Idle source: a granted source deasserting tvalid mid-packet stalls the block; no timeout, and other ports stay blocked.
- Reset mid-packet: the partial packet is abandoned; any output beat pending in the register is cleared (tvalid=0).

Decomposition:
- Shared package (rmt_pkg):
  - ETHERTYPE_IPV4_LE = 16'h0008, RMT_DELIM = 16'hF0E1;
  - byte offsets: 12, 26, 30, 34, 36, 40, 42, 44, HDR_BYTES=46;
  - state encodings IDLE/TRANSFER/DROP.
- The ingress classifier uses the same package constants.
- One sub-module: rmt_rr_arbiter (S_COUNT request vector, pointer in, grant index + valid out, combinational).

Test Plan:
- Single 64-byte packet on port 1:
  - src MAC 02:00:00:00:00:01, dst MAC 02:00:00:00:00:02, IP 10.0.0.1 -> 10.0.0.2, ports 1234 -> 5678;
  - required output one cycle after handshake: MACs swapped, IPs swapped, ports 5678 -> 1234;
  - required output fields: tdata[42*8+:16]=F0E1, tdata[44*8+:16]=0001, tdata[40*8+:16]=0000;
  - stat_pkt_count=1.
- Ports 0 and 1 both valid with 3-beat packets:
  - required: port 0 packet fully out, then port 1 packet;
  - required: no interleaving; func_type 0000 then 0001; beats 2-3 of each unmodified.
- m_axis_tready toggled 1,0,0,1 during a 4-beat packet: required no beat lost or duplicated, and data held stable while stalled.
- 40-byte single-beat packet (tkeep[45:0] incomplete): required no output and stat_drop_count=1. Then a 3-beat packet with a 32-byte first beat: required all 3 beats consumed, nothing output, stat_drop_count=2.
- rst asserted during beat 2 of a 4-beat packet: required m_axis_tvalid=0 the next cycle, counters=0, and the next fresh packet forwarded intact.
- Back-to-back single-beat packets on port 0 with tready=1: required one output per cycle (full throughput).
